// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive core and its transmit-side sibling.
// Contains the receiver state encoding, the frame width and a baud-divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  localparam int UART_DATA_BITS = 8;

  // Rounded to the nearest whole clock: 50 MHz / 115200 gives 434.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Byte-side bundle of the UART receiver, plus the serial pin it samples.
// rx_done is a valid-only strobe with no ready: a byte is offered for exactly one cycle
// and rx_data keeps holding it afterwards, so a consumer may also read it later.
interface uart_rx_core_if;
  import uart_pkg::*;

  logic                      uart_rx;
  logic                      rx_done;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_frame_err;
  logic                      rx_busy;

  modport master (
    input  uart_rx,
    output rx_done, rx_data, rx_frame_err, rx_busy
  );

  modport slave (
    output uart_rx,
    input  rx_done, rx_data, rx_frame_err, rx_busy
  );

endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Reset value is a parameter so idle-high lines come out of reset inactive.
module uart_sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: synchronises uart_rx, samples each bit at its midpoint and
// presents good bytes with a one-cycle rx_done strobe; bad stop bits strobe rx_frame_err.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_core_if.master bus,
  output uart_rx_state_e state
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rxs;
  uart_rx_state_e       state_nx;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q, err_q, busy_q;
  logic                 done_nx, err_nx, sample, cnt_clr, busy_nx;

  uart_sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.uart_rx),
    .q     (rxs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!rxs) state_nx = START;
      START:   if (cnt == CNT_HALF) state_nx = rxs ? IDLE : DATA;
      DATA:    if (cnt == CNT_FULL && bit_idx == LAST_BIT) state_nx = STOP;
      STOP:    if (cnt == CNT_FULL) state_nx = rxs ? IDLE : BREAK;
      BREAK:   if (rxs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The counter restarts on every state change and after every data sample,
  // so START measures half a bit and each later phase a whole bit.
  always_comb begin
    done_nx = (state == STOP) && (cnt == CNT_FULL) && rxs;
    err_nx  = (state == STOP) && (cnt == CNT_FULL) && !rxs;
    sample  = (state == DATA) && (cnt == CNT_FULL);
    cnt_clr = (state != state_nx) || sample || (state == IDLE) || (state == BREAK);
    busy_nx = (state_nx == START) || (state_nx == DATA) || (state_nx == STOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt     <= cnt_clr ? '0 : cnt + CW'(1);
      done_q  <= done_nx;
      err_q   <= err_nx;
      busy_q  <= busy_nx;
      if (state_nx == DATA && state != DATA) bit_idx <= '0;
      else if (sample)                       bit_idx <= bit_idx + 3'd1;
      if (sample)  shreg  <= {rxs, shreg[DATA_BITS-1:1]};
      if (done_nx) data_q <= shreg;
    end
  end

  assign bus.rx_done      = done_q;
  assign bus.rx_frame_err = err_q;
  assign bus.rx_busy      = busy_q;
  assign bus.rx_data      = data_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a 16-clk/bit instance for the functional cases
// and a 434-clk/bit instance for baud-skew tolerance.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int CPB_A = 16;
  localparam int CPB_B = 434;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_core_if bus_a ();
  uart_rx_core_if bus_b ();
  uart_rx_state_e state_a, state_b;

  uart_rx_core #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .state(state_a)
  );
  uart_rx_core #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .state(state_b)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic [7:0] exp_q[$];
  int         done_a_t[$];
  int         done_b_t[$];
  logic [7:0] data_b_q[$];
  int         err_a_cnt = 0, err_b_cnt = 0;
  int         both_hi = 0, stretch = 0;
  logic       prev_done_a = 0, prev_err_a = 0, prev_done_b = 0, prev_err_b = 0;

  always @(negedge clk) begin
    if (bus_a.rx_done) begin
      done_a_t.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected rx_done", {24'h0, bus_a.rx_data}, 32'hFFFF_FFFF);
      else check("scoreboard rx_data", {24'h0, bus_a.rx_data}, {24'h0, exp_q.pop_front()});
    end
    if (bus_a.rx_frame_err) err_a_cnt++;
    if (bus_b.rx_done) begin
      done_b_t.push_back(cyc);
      data_b_q.push_back(bus_b.rx_data);
    end
    if (bus_b.rx_frame_err) err_b_cnt++;
    if ((bus_a.rx_done && bus_a.rx_frame_err) || (bus_b.rx_done && bus_b.rx_frame_err)) both_hi++;
    if ((bus_a.rx_done && prev_done_a) || (bus_a.rx_frame_err && prev_err_a) ||
        (bus_b.rx_done && prev_done_b) || (bus_b.rx_frame_err && prev_err_b)) stretch++;
    prev_done_a = bus_a.rx_done;
    prev_err_a  = bus_a.rx_frame_err;
    prev_done_b = bus_b.rx_done;
    prev_err_b  = bus_b.rx_frame_err;
  end

  // ---------------- driver tasks ----------------
  int start_cyc;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) bus_a.uart_rx = v;
    else            bus_b.uart_rx = v;
  endtask

  // stop_low > 0 holds the stop bit low that many clocks before releasing the line.
  task automatic send_frame(input int which, input logic [7:0] d, input int bit_clks,
                            input int stop_low);
    start_cyc = cyc;
    set_line(which, 1'b0);
    idle(bit_clks);
    for (int i = 0; i < 8; i++) begin
      set_line(which, d[i]);
      idle(bit_clks);
    end
    if (stop_low > 0) begin
      set_line(which, 1'b0);
      idle(stop_low);
    end
    set_line(which, 1'b1);
    idle(bit_clks);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    int         stop_low;
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  localparam int NV = 5;
  vec_t vec[NV];

  int   d0, e0, lat;
  logic saw_busy;

  initial begin
    vec[0] = '{8'hA5, 0,  1'b1, 1'b0, 8'hA5};
    vec[1] = '{8'h3C, 40, 1'b0, 1'b1, 8'hA5};
    vec[2] = '{8'h81, 0,  1'b1, 1'b0, 8'h81};
    vec[3] = '{8'h7E, 0,  1'b1, 1'b0, 8'h7E};
    vec[4] = '{8'h01, 0,  1'b1, 1'b0, 8'h01};

    bus_a.uart_rx = 1'b1;
    bus_b.uart_rx = 1'b1;
    idle(3);
    check("reset rx_done",      {31'h0, bus_a.rx_done},      0);
    check("reset rx_frame_err", {31'h0, bus_a.rx_frame_err}, 0);
    check("reset rx_busy",      {31'h0, bus_a.rx_busy},      0);
    check("reset rx_data",      {24'h0, bus_a.rx_data},      0);
    check("reset state",        32'(state_a),                32'(IDLE));
    rst_n = 1'b1;
    idle(5);

    for (int v = 0; v < NV; v++) begin
      d0 = done_a_t.size();
      e0 = err_a_cnt;
      if (vec[v].exp_done) exp_q.push_back(vec[v].data);
      send_frame(0, vec[v].data, CPB_A, vec[v].stop_low);
      idle(4);
      check($sformatf("vec%0d done count", v), done_a_t.size() - d0, {31'h0, vec[v].exp_done});
      check($sformatf("vec%0d err count", v), err_a_cnt - e0, {31'h0, vec[v].exp_err});
      check($sformatf("vec%0d rx_data", v), {24'h0, bus_a.rx_data}, {24'h0, vec[v].exp_data});
      check($sformatf("vec%0d busy after", v), {31'h0, bus_a.rx_busy}, 0);
      if (vec[v].exp_done && done_a_t.size() > d0) begin
        lat = done_a_t[d0] - start_cyc;
        check($sformatf("vec%0d latency", v),
              {31'h0, (lat >= 19 * CPB_A / 2 + 2) && (lat <= 19 * CPB_A / 2 + 4)}, 1);
      end
    end

    // Back-to-back 0x00, 0xFF with no idle gap.
    d0 = done_a_t.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(0, 8'h00, CPB_A, 0);
    send_frame(0, 8'hFF, CPB_A, 0);
    idle(4);
    check("b2b done count", done_a_t.size() - d0, 2);
    if (done_a_t.size() >= d0 + 2) check("b2b spacing", done_a_t[d0+1] - done_a_t[d0], 160);
    check("b2b rx_data", {24'h0, bus_a.rx_data}, 32'hFF);

    // Four-clock low glitch on an idle line.
    d0 = done_a_t.size();
    e0 = err_a_cnt;
    saw_busy = 1'b0;
    set_line(0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3) set_line(0, 1'b1);
      if (bus_a.rx_busy) saw_busy = 1'b1;
    end
    check("glitch busy pulsed", {31'h0, saw_busy}, 1);
    check("glitch busy cleared", {31'h0, bus_a.rx_busy}, 0);
    idle(40);
    check("glitch no done", done_a_t.size() - d0, 0);
    check("glitch no err", err_a_cnt - e0, 0);

    // Asynchronous reset in the middle of data bit 4 of 0x5A.
    fork
      send_frame(0, 8'h5A, CPB_A, 0);
      begin
        idle(CPB_A * 5 + CPB_A / 2);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy",  {31'h0, bus_a.rx_busy}, 0);
        check("midreset data",  {24'h0, bus_a.rx_data}, 0);
        check("midreset done",  {31'h0, bus_a.rx_done}, 0);
        check("midreset state", 32'(state_a), 32'(IDLE));
      end
    join
    idle(4);
    rst_n = 1'b1;
    idle(20);
    exp_q.push_back(8'hC3);
    send_frame(0, 8'hC3, CPB_A, 0);
    idle(4);
    check("post-reset rx_data", {24'h0, bus_a.rx_data}, 32'hC3);

    // 0x55 at +2% and -2% baud on the 434-clk/bit instance.
    for (int s = 0; s < 2; s++) begin
      d0 = done_b_t.size();
      send_frame(1, 8'h55, (s == 0) ? 443 : 425, 0);
      idle(4);
      check($sformatf("skew%0d done count", s), done_b_t.size() - d0, 1);
      if (done_b_t.size() > d0) begin
        lat = done_b_t[d0] - start_cyc;
        check($sformatf("skew%0d rx_data", s), {24'h0, data_b_q[d0]}, 32'h55);
        check($sformatf("skew%0d latency", s),
              {31'h0, (lat >= 19 * CPB_B / 2 + 2) && (lat <= 19 * CPB_B / 2 + 4)}, 1);
      end
    end
    check("skew err count", err_b_cnt, 0);

    check("strobes overlap", both_hi, 0);
    check("strobe stretched", stretch, 0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
